// File: rtl/muldiv_unit_pkg.sv
// Shared HI/LO unit op codes and small decode helpers.
// Codes 4'hA..4'hF are unassigned and ignored by the unit.
package muldiv_unit_pkg;

  localparam logic [3:0] mulMULT  = 4'h0;
  localparam logic [3:0] mulMULTU = 4'h1;
  localparam logic [3:0] mulMADD  = 4'h2;
  localparam logic [3:0] mulMADDU = 4'h3;
  localparam logic [3:0] mulMSUB  = 4'h4;
  localparam logic [3:0] mulMSUBU = 4'h5;
  localparam logic [3:0] mulDIV   = 4'h6;
  localparam logic [3:0] mulDIVU  = 4'h7;
  localparam logic [3:0] mulSetLO = 4'h8;
  localparam logic [3:0] mulSetHI = 4'h9;

  function automatic logic f_is_mul(input logic [3:0] f);
    return f inside {mulMULT, mulMULTU, mulMADD, mulMADDU, mulMSUB, mulMSUBU};
  endfunction

  function automatic logic f_is_div(input logic [3:0] f);
    return f inside {mulDIV, mulDIVU};
  endfunction

  function automatic logic f_is_signed(input logic [3:0] f);
    return f inside {mulMULT, mulMADD, mulMSUB, mulDIV};
  endfunction

  function automatic logic f_is_known(input logic [3:0] f);
    return f_is_mul(f) || f_is_div(f) || (f == mulSetLO) || (f == mulSetHI);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: magnitude load, one quotient bit per step,
// sign fix-up applied combinationally on the outputs.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_sgn_a;
  logic             w_sgn_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_sgn_a = i_signed & i_dividend[WIDTH-1];
  assign w_sgn_b = i_signed & i_divisor[WIDTH-1];
  // Negating MIN wraps back to MIN, which read unsigned is the right magnitude.
  assign w_mag_a = w_sgn_a ? (~i_dividend + 1'b1) : i_dividend;
  assign w_mag_b = w_sgn_b ? (~i_divisor + 1'b1) : i_divisor;

  // Dividend bits shift out of the quotient register into the partial remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_quo   <= w_mag_a;
      r_rem   <= '0;
      r_dvs   <= w_mag_b;
      r_neg_q <= w_sgn_a ^ w_sgn_b;
      r_neg_r <= w_sgn_a;
    end else if (i_step) begin
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quotient  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign o_remainder = r_neg_r ? (~r_rem + 1'b1) : r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply-class ops, iterative
// divide, early divide-by-zero completion, flush abort and done strobe.
//
// state  | meaning
// IDLE   | accepting ops; SetHI/SetLO and divide-by-zero finish here
// MUL    | counting down MUL_LAT, product written back at terminal count
// DIV    | setup load, WIDTH restoring steps, then signed writeback
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_DIV_W = $clog2(WIDTH + 2);
  localparam int CNT_MUL_W = $clog2(MUL_LAT + 1);
  localparam int CNT_W     = (CNT_DIV_W > CNT_MUL_W) ? CNT_DIV_W : CNT_MUL_W;
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_func;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz;
  logic               r_dz_pend;

  logic               w_accept;
  logic               w_mul_wb;
  logic               w_div_wb;
  logic               w_load;
  logic               w_step;
  logic               w_dec;
  logic               w_dz;

  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_mul_res;
  logic               w_sgn;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mul_wb    = 1'b0;
    w_div_wb    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_dec       = 1'b0;
    w_dz        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush && f_is_known(func)) begin
          w_accept = 1'b1;
          if (f_is_mul(func)) begin
            w_state_nxt = S_MUL;
          end else if (f_is_div(func)) begin
            if (b != '0) w_state_nxt = S_DIV;
            else         w_dz = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_mul_wb    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_DIV: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_div_wb    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_dec  = 1'b1;
          w_load = (r_cnt == DIV_CNT);
          w_step = (r_cnt != DIV_CNT);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sgn   = f_is_signed(r_func);
  assign w_ext_a = w_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b = w_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign w_acc   = {r_hi, r_lo};

  always_comb begin
    w_mul_res = w_prod;
    case (r_func)
      mulMADD, mulMADDU: w_mul_res = w_acc + w_prod;
      mulMSUB, mulMSUBU: w_mul_res = w_acc - w_prod;
      default:           w_mul_res = w_prod;
    endcase
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_signed    (w_sgn),
    .i_dividend  (r_a),
    .i_divisor   (r_b),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_func    <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
    end else begin
      r_done    <= w_mul_wb | w_div_wb | r_dz_pend;
      r_dz_pend <= w_dz;
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_func <= func;
        r_dz   <= 1'b0;
        r_cnt  <= f_is_div(func) ? DIV_CNT : MUL_CNT;
        if (func == mulSetHI) r_hi <= a;
        if (func == mulSetLO) r_lo <= a;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // A divide-by-zero resolving here outranks a clear from a same-edge accept.
      if (r_dz_pend) r_dz <= 1'b1;
      if (w_mul_wb) {r_hi, r_lo} <= w_mul_res;
      if (w_div_wb) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised HI/LO multiply/divide unit for the CPU execute stage, the successor to the fixed-latency 32-bit multiplier. Multiplies complete after a configurable latency. Divides run on a true iterative restoring divider with data-independent latency. The unit adds early divide-by-zero termination, a pipeline flush that aborts work in flight, and a one-cycle completion strobe.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `MUL_LAT`, default 5: accept-to-writeback latency for multiply-class ops; legal values are 1 and above.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `a`  in  WIDTH  operand A; also the data source for SetHI and SetLO.
- `b`  in  WIDTH  operand B.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `func`  in  4  op code: `mulMULT`, `mulMULTU`, `mulMADD`, `mulMADDU`, `mulMSUB`, `mulMSUBU`, `mulDIV`, `mulDIVU`, `mulSetLO`, `mulSetHI`.
- `flush`  in  1  synchronous abort of the in-flight op.
- `busy`  out  1  a multi-cycle op is in flight.
- `done`  out  1  one-cycle pulse at the cycle after writeback.
- `div_by_zero`  out  1  the last completed divide had `b`=0.
- `hi`, `lo`  out  WIDTH  result registers.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, state=IDLE, operand and counter registers=0.
- States and transitions:
  - IDLE → MUL when a multiply-class op is accepted.
  - IDLE → DIV when a divide is accepted with `b`≠0.
  - IDLE → IDLE for SetHI, SetLO, and divide with `b`=0.
  - MUL or DIV → IDLE on completion or on `flush`.
- Accept edge (`start`=1, `busy`=0, `flush`=0):
  - Latch `a`, `b` and `func`.
  - Clear `div_by_zero`.
  - Unknown `func` codes are ignored.
- SetHI and SetLO write `a` to `hi` or `lo` at the accept edge. No `busy`, no `done`.
- Multiply-class ops:
  - The full 2·WIDTH product is formed from the latched operands: signed for MULT/MADD/MSUB, unsigned for the U variants.
  - MADD and MSUB use `{hi,lo}` as it stands at the writeback edge, modulo 2^(2·WIDTH).
- DIV and DIVU:
  - One setup cycle converts operands to magnitudes (signed ops only).
  - WIDTH restoring iterations follow, one quotient bit per cycle.
  - One fix-up cycle applies signs: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
  - Writeback: `lo`=quotient, `hi`=remainder.
  - MIN/−1 yields `lo`=MIN, `hi`=0.
- Divide with `b`=0:
  - Completes at accept+1.
  - `hi` and `lo` are unchanged.
  - `div_by_zero`=1 and `done` pulses.
  - `busy` stays 0.
- Flush:
  - With `busy`=1, state returns to IDLE at the next edge.
  - `hi` and `lo` are unchanged, no `done`, `div_by_zero` is unchanged.
  - `flush` together with `start` on the same edge: the start is dropped.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Accept edge is E0. `busy` rises at E0.
- Writeback and `busy` falling happen at the same edge:
  - E0+`MUL_LAT` for multiply-class ops.
  - E0+`WIDTH`+2 for divides (34 at the default width).
- `done` is high for exactly the cycle following writeback.
- Back-to-back: a new `start` may be accepted on the writeback edge's successor, i.e. whenever `busy` is sampled 0.
- Asynchronous reset mid-operation clears everything immediately; no partial writeback occurs.

## Structure
- Func encodings stay in the shared constants header; this unit adds no new codes.
- The state enum and iteration counter width (`$clog2(WIDTH+2)`) are local.
- One sub-module: `div_iter`, the restoring-division datapath (magnitudes, shift/subtract, sign fix-up), driven by a step enable and a load strobe. Multiply and control logic live in `muldiv_unit`.

## Test plan
All scenarios use WIDTH=32, MUL_LAT=5.
- MULT, `a`=0xFFFFFFFE, `b`=3:
  - `busy` is high for 5 cycles.
  - At E0+5: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - `done` pulses once.
- MULTU, same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- MADD:
  - Preload via SetHI=0 and SetLO=0xFFFFFFFF.
  - `a`=1, `b`=1 → `hi`=1, `lo`=0.
- DIV:
  - `a`=−7, `b`=2 → at E0+34, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 0x80000000 / 0xFFFFFFFF → `lo`=0, `hi`=0x80000000.
- Divide by zero:
  - Preload `hi`=0x11, `lo`=0x22.
  - DIVU with `b`=0 → `done` at E0+1, `div_by_zero`=1, `hi`/`lo` unchanged, `busy` never rises.
- Flush and reset:
  - `flush` at E0+10 of a DIV → `busy` is 0 at the next edge, `hi`/`lo` unchanged, no `done`.
  - `start` issued during `busy` is ignored.
  - `rst_n` low mid-MULT → all outputs are 0 immediately.
